// File: rtl/dbram_pkg.sv
// Shared types and widths for the double-buffered RAM ping-pong writer.
// Tile-early-close support is enabled by the DBRAM_WRITER_TILE_LAST_EN macro.
package dbram_pkg;

    localparam int DBRAM_AWIDTH  = 12;
    localparam int DBRAM_DWIDTH  = 60;
    localparam int DBRAM_NBANKS  = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        WAIT_BANK = 2'd2
    } wr_state_t;

    typedef logic bank_sel_t;

    function automatic logic [DBRAM_NBANKS-1:0] bank_onehot(input bank_sel_t b);
        return b ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dbram_pingpong_writer_if.sv
// Producer word stream plus RAM port A write bus; in_last exists only with DBRAM_WRITER_TILE_LAST_EN.
// slave = the writer, master = the producer / RAM-side observer.
interface dbram_pingpong_writer_if
    import dbram_pkg::*;
#(
    parameter int AWIDTH = DBRAM_AWIDTH,
    parameter int DWIDTH = DBRAM_DWIDTH
) ();

    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_ready;
`ifdef DBRAM_WRITER_TILE_LAST_EN
    logic              in_last;
`endif
    logic [AWIDTH-1:0] ram_address;
    logic              ram_wren;
    logic [DWIDTH-1:0] ram_data;

    modport slave (
        input  in_valid,
        input  in_data,
`ifdef DBRAM_WRITER_TILE_LAST_EN
        input  in_last,
`endif
        output in_ready,
        output ram_address,
        output ram_wren,
        output ram_data
    );

    modport master (
        output in_valid,
        output in_data,
`ifdef DBRAM_WRITER_TILE_LAST_EN
        output in_last,
`endif
        input  in_ready,
        input  ram_address,
        input  ram_wren,
        input  ram_data
    );

endinterface

// File: rtl/dbram_bank_tracker.sv
// Bank ownership flags: set by the writer on tile close, cleared by consumer release.
// Registered, 1-cycle update; a release of a bank not owned by the consumer is dropped and flagged sticky.
module dbram_bank_tracker
    import dbram_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DBRAM_NBANKS-1:0] bank_set,
    input  logic [DBRAM_NBANKS-1:0] bank_release,
    output logic [DBRAM_NBANKS-1:0] bank_full,
    output logic                    err_release
);

    logic [DBRAM_NBANKS-1:0] r_full;
    logic                    r_err;

    // The writer never closes a tile into a full bank, so set and release never collide on one bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= '0;
            r_err  <= 1'b0;
        end else begin
            r_full <= (r_full & ~bank_release) | bank_set;
            if (|(bank_release & ~r_full)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bank_full   = r_full;
    assign err_release = r_err;

endmodule

// File: rtl/dbram_pingpong_writer.sv
// Ping-pong fill stage for RAM port A; words land on the RAM 1 cycle after acceptance.
// in_ready drops while the next bank is still owned by the consumer. Optional: DBRAM_WRITER_TILE_LAST_EN.
module dbram_pingpong_writer
    import dbram_pkg::*;
#(
    parameter int AWIDTH     = DBRAM_AWIDTH,
    parameter int DWIDTH     = DBRAM_DWIDTH,
    parameter int TILE_WORDS = 2048
) (
    input  logic                    clk,
    input  logic                    reset,
    dbram_pingpong_writer_if.slave  bus,
    output logic [DBRAM_NBANKS-1:0] bank_full,
    input  logic [DBRAM_NBANKS-1:0] bank_release,
    output logic                    err_release
`ifdef DBRAM_WRITER_TILE_LAST_EN
    ,
    output logic [2*AWIDTH-1:0]     tile_len
`endif
);

    localparam int                OWIDTH   = AWIDTH - 1;
    localparam logic [OWIDTH-1:0] LAST_OFF = OWIDTH'(TILE_WORDS - 1);

    wr_state_t               r_state;
    wr_state_t               w_state_nxt;
    bank_sel_t               r_wr_bank;
    logic [OWIDTH-1:0]       r_offset;
    logic                    r_ram_wren;
    logic [AWIDTH-1:0]       r_ram_address;
    logic [DWIDTH-1:0]       r_ram_data;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_tile_end;
    logic                    w_other_busy;
    logic                    w_target_free;
    logic [DBRAM_NBANKS-1:0] w_set;

    assign w_accept = bus.in_valid & w_in_ready;

`ifdef DBRAM_WRITER_TILE_LAST_EN
    assign w_tile_end = (r_offset == LAST_OFF) | bus.in_last;
`else
    assign w_tile_end = (r_offset == LAST_OFF);
`endif

    // A release arriving this cycle already counts, so no bubble is spent waiting on the flag.
    assign w_other_busy  = bank_full[~r_wr_bank] & ~bank_release[~r_wr_bank];
    assign w_target_free = ~bank_full[r_wr_bank] | bank_release[r_wr_bank];
    assign w_set         = (w_accept & w_tile_end) ? bank_onehot(r_wr_bank) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, FILL: begin
                if (w_accept) begin
                    w_state_nxt = (w_tile_end && w_other_busy) ? WAIT_BANK : FILL;
                end
            end
            WAIT_BANK: begin
                if (w_target_free) begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = (r_state != WAIT_BANK) & ~reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ram_wren    <= 1'b0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_wr_bank     <= 1'b0;
            r_offset      <= '0;
        end else begin
            r_ram_wren <= w_accept;
            if (w_accept) begin
                r_ram_address <= {r_wr_bank, r_offset};
                r_ram_data    <= bus.in_data;
                if (w_tile_end) begin
                    r_offset  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_offset  <= r_offset + 1'b1;
                end
            end
        end
    end

`ifdef DBRAM_WRITER_TILE_LAST_EN
    logic [2*AWIDTH-1:0] r_tile_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tile_len <= '0;
        end else if (w_accept && w_tile_end) begin
            if (r_wr_bank) begin
                r_tile_len[2*AWIDTH-1:AWIDTH] <= {1'b0, r_offset} + 1'b1;
            end else begin
                r_tile_len[AWIDTH-1:0] <= {1'b0, r_offset} + 1'b1;
            end
        end
    end

    assign tile_len = r_tile_len;
`endif

    dbram_bank_tracker u_tracker (
        .clk          (clk),
        .reset        (reset),
        .bank_set     (w_set),
        .bank_release (bank_release),
        .bank_full    (bank_full),
        .err_release  (err_release)
    );

    assign bus.in_ready    = w_in_ready;
    assign bus.ram_wren    = r_ram_wren;
    assign bus.ram_address = r_ram_address;
    assign bus.ram_data    = r_ram_data;

endmodule
